// File: rtl/enc16_pkg.sv
// Shared constants, FSM state type and popcount helper for the 16-to-4 request encoder.
// ENC_ROUND_ROBIN_EN (top-level build macro) does not change anything in this package.
package enc16_pkg;
    localparam int CODE_W = 4;
    localparam int N_REQ  = 16;

    typedef enum logic {IDLE, SHOW} state_e;

    function automatic logic [4:0] popcount16(input logic [0:N_REQ-1] v);
        logic [4:0] c;
        c = 5'd0;
        for (int i = 0; i < N_REQ; i++) begin
            c = c + {4'd0, v[i]};
        end
        return c;
    endfunction
endpackage

// File: rtl/enc16_4_queue_if.sv
// Request/code handshake bundle between event sources, the encoder and the code consumer.
// Y[i] requests code i; W/Valid/Ready is a standard valid-ready transfer.
interface enc16_4_queue_if;
    import enc16_pkg::*;

    logic                Enable;
    logic [0:N_REQ-1]    Y;
    logic [CODE_W-1:0]   W;
    logic                Valid;
    logic                Ready;
    logic [CODE_W:0]     Pending;

    modport slave  (input Enable, Y, Ready, output W, Valid, Pending);
    modport master (output Enable, Y, Ready, input W, Valid, Pending);
endinterface

// File: rtl/prio_pick16.sv
// Combinational 16-way priority picker: first set req bit at or above base, wrapping 15->0.
// Zero latency, no backpressure; any=0 when req is empty (code is then 0).
module prio_pick16 (
    input  logic [0:15] req,
    input  logic [3:0]  base,
    output logic [3:0]  code,
    output logic        any
);
    logic [3:0] idx;

    // Scan farthest offset first so the nearest hit to base is the one left standing.
    always_comb begin
        code = 4'd0;
        any  = 1'b0;
        idx  = 4'd0;
        for (int k = 15; k >= 0; k--) begin
            idx = base + 4'(k);
            if (req[idx]) begin
                code = idx;
                any  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/enc16_4_queue.sv
// Sticky 16-request set emitting one 4-bit code per request; request-to-Valid is 2 edges, back-to-back 1 code/cycle.
// W is held while Valid && !Ready; ENC_ROUND_ROBIN_EN rotates priority past the last transferred code.
module enc16_4_queue #(
    parameter int CODE_W = 4
) (
    input  logic              Clock,
    input  logic              Resetn,
    enc16_4_queue_if.slave    bus
);
    import enc16_pkg::*;

    state_e              state_q, state_d;
    logic [0:N_REQ-1]    pend_q, pend_d, clr, avail;
    logic [CODE_W-1:0]   w_q, w_d, rr_base, pick;
    logic [CODE_W:0]     cnt_q;
    logic                pick_any, xfer;

    assign xfer = (state_q == SHOW) && bus.Ready;

    always_comb begin
        clr = '0;
        if (xfer) clr[w_q] = 1'b1;
    end

    // Selection sees only the registered set, so a same-cycle request never jumps the queue.
    assign avail  = pend_q & ~clr;
    assign pend_d = avail | (bus.Enable ? bus.Y : '0);

`ifdef ENC_ROUND_ROBIN_EN
    logic [CODE_W-1:0] rr_ptr_q;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn)   rr_ptr_q <= '0;
        else if (xfer) rr_ptr_q <= w_q + 4'd1;
    end

    assign rr_base = rr_ptr_q;
`else
    assign rr_base = '0;
`endif

    prio_pick16 u_pick (
        .req  (avail),
        .base (rr_base),
        .code (pick),
        .any  (pick_any)
    );

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    w_d     = pick;
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (xfer) begin
                    if (pick_any) w_d     = pick;
                    else          state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= IDLE;
            w_q     <= '0;
            pend_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            pend_q  <= pend_d;
            cnt_q   <= popcount16(pend_d);
        end
    end

    assign bus.W       = w_q;
    assign bus.Valid   = (state_q == SHOW);
    assign bus.Pending = cnt_q;
endmodule

// File: tb/tb_enc16_4_queue.sv
// Scenario bench for enc16_4_queue: expected codes are queued at stimulus time and popped on each transfer.
module tb_enc16_4_queue;
    logic Clock = 1'b0;
    logic Resetn = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   exp_q[$];

    enc16_4_queue_if bus ();

    enc16_4_queue #(.CODE_W(4)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus)
    );

    always #5 Clock = ~Clock;

    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        Resetn     = 1'b0;
        bus.Y      = '0;
        bus.Enable = 1'b0;
        bus.Ready  = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge Clock);
        #1;
        Resetn = 1'b1;
    endtask

    task automatic test_reset();
        int n;
        int e;
        Resetn     = 1'b0;
        bus.Y      = '1;
        bus.Enable = 1'b1;
        bus.Ready  = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge Clock);
        #1;
        total++; if (bus.W !== 4'd0)       begin bad++; $display("FAIL rst_W got=%0d want=0", bus.W); end
        total++; if (bus.Valid !== 1'b0)   begin bad++; $display("FAIL rst_Valid got=%b want=0", bus.Valid); end
        total++; if (bus.Pending !== 5'd0) begin bad++; $display("FAIL rst_Pending got=%0d want=0", bus.Pending); end
        Resetn = 1'b1;
        cyc();
        total++; if (bus.Valid !== 1'b0)    begin bad++; $display("FAIL rst_edge1_Valid got=%b want=0", bus.Valid); end
        total++; if (bus.Pending !== 5'd16) begin bad++; $display("FAIL rst_edge1_Pending got=%0d want=16", bus.Pending); end
        cyc();
        total++; if (bus.Valid !== 1'b1)    begin bad++; $display("FAIL rst_edge2_Valid got=%b want=1", bus.Valid); end
        total++; if (bus.W !== 4'd0)        begin bad++; $display("FAIL rst_edge2_W got=%0d want=0", bus.W); end
        total++; if (bus.Pending !== 5'd16) begin bad++; $display("FAIL rst_edge2_Pending got=%0d want=16", bus.Pending); end
        bus.Enable = 1'b0;
        bus.Y      = '0;
        bus.Ready  = 1'b1;
        for (int i = 0; i < 16; i++) exp_q.push_back(i);
        n = 0;
        while ((exp_q.size() != 0 || bus.Valid) && n < 40) begin
            if (bus.Valid && bus.Ready) begin
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL all16_extra got=%0d want=none", bus.W); end
                else begin
                    e = exp_q.pop_front();
                    if (bus.W !== 4'(e)) begin bad++; $display("FAIL all16_order got=%0d want=%0d", bus.W, e); end
                end
            end
            cyc();
            n++;
        end
        total++; if (exp_q.size() != 0 || bus.Valid) begin bad++; $display("FAIL all16_drain left=%0d want=0", exp_q.size()); end
        total++; if (bus.Pending !== 5'd0) begin bad++; $display("FAIL all16_Pending got=%0d want=0", bus.Pending); end
    endtask

    task automatic test_single();
        do_reset();
        bus.Enable = 1'b1;
        bus.Ready  = 1'b1;
        bus.Y[5]   = 1'b1;
        exp_q.push_back(5);
        cyc();
        bus.Y = '0;
        total++; if (bus.Valid !== 1'b0)   begin bad++; $display("FAIL single_lat_Valid got=%b want=0", bus.Valid); end
        total++; if (bus.Pending !== 5'd1) begin bad++; $display("FAIL single_lat_Pending got=%0d want=1", bus.Pending); end
        cyc();
        total++; if (bus.Valid !== 1'b1) begin bad++; $display("FAIL single_Valid got=%b want=1", bus.Valid); end
        total++; if (bus.W !== 4'(exp_q.pop_front())) begin bad++; $display("FAIL single_W got=%0d want=5", bus.W); end
        cyc();
        total++; if (bus.Valid !== 1'b0)   begin bad++; $display("FAIL single_drop_Valid got=%b want=0", bus.Valid); end
        total++; if (bus.Pending !== 5'd0) begin bad++; $display("FAIL single_drop_Pending got=%0d want=0", bus.Pending); end
    endtask

    task automatic test_back_to_back();
        int e;
        do_reset();
        bus.Enable = 1'b1;
        bus.Ready  = 1'b1;
        bus.Y[3]   = 1'b1;
        bus.Y[9]   = 1'b1;
        bus.Y[12]  = 1'b1;
        exp_q.push_back(3);
        exp_q.push_back(9);
        exp_q.push_back(12);
        cyc();
        bus.Y = '0;
        cyc();
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            total++; if (bus.Valid !== 1'b1) begin bad++; $display("FAIL b2b_bubble step=%0d got=%b want=1", i, bus.Valid); end
            total++; if (bus.W !== 4'(e)) begin bad++; $display("FAIL b2b_W step=%0d got=%0d want=%0d", i, bus.W, e); end
            total++; if (bus.Pending !== 5'(3 - i)) begin bad++; $display("FAIL b2b_Pending step=%0d got=%0d want=%0d", i, bus.Pending, 3 - i); end
            cyc();
        end
        total++; if (bus.Valid !== 1'b0)   begin bad++; $display("FAIL b2b_end_Valid got=%b want=0", bus.Valid); end
        total++; if (bus.Pending !== 5'd0) begin bad++; $display("FAIL b2b_end_Pending got=%0d want=0", bus.Pending); end
    endtask

    task automatic test_stall();
        int n;
        int e;
        do_reset();
        bus.Enable = 1'b1;
        bus.Y[2]   = 1'b1;
        bus.Y[7]   = 1'b1;
        exp_q.push_back(2);
        exp_q.push_back(7);
        cyc();
        bus.Y = '0;
        cyc();
        for (int i = 0; i < 5; i++) begin
            total++; if (bus.Valid !== 1'b1 || bus.W !== 4'd2) begin bad++; $display("FAIL stall_hold cyc=%0d got=%b/%0d want=1/2", i, bus.Valid, bus.W); end
            cyc();
        end
        bus.Ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || bus.Valid) && n < 10) begin
            if (bus.Valid && bus.Ready) begin
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL stall_extra got=%0d want=none", bus.W); end
                else begin
                    e = exp_q.pop_front();
                    if (bus.W !== 4'(e)) begin bad++; $display("FAIL stall_order got=%0d want=%0d", bus.W, e); end
                end
            end
            cyc();
            n++;
        end
        total++; if (exp_q.size() != 0 || bus.Valid) begin bad++; $display("FAIL stall_drain left=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_set_wins();
        int n;
        int e;
        do_reset();
        bus.Enable = 1'b1;
        bus.Y[4]   = 1'b1;
        bus.Y[6]   = 1'b1;
        exp_q.push_back(4);
        exp_q.push_back(6);
        exp_q.push_back(4);
        cyc();
        bus.Y = '0;
        cyc();
        bus.Ready = 1'b1;
        bus.Y[4]  = 1'b1;
        e = exp_q.pop_front();
        total++; if (bus.Valid !== 1'b1 || bus.W !== 4'(e)) begin bad++; $display("FAIL setwin_first got=%b/%0d want=1/%0d", bus.Valid, bus.W, e); end
        cyc();
        bus.Y = '0;
        total++; if (bus.Pending !== 5'd2) begin bad++; $display("FAIL setwin_Pending got=%0d want=2", bus.Pending); end
        n = 0;
        while ((exp_q.size() != 0 || bus.Valid) && n < 10) begin
            if (bus.Valid && bus.Ready) begin
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL setwin_extra got=%0d want=none", bus.W); end
                else begin
                    e = exp_q.pop_front();
                    if (bus.W !== 4'(e)) begin bad++; $display("FAIL setwin_order got=%0d want=%0d", bus.W, e); end
                end
            end
            cyc();
            n++;
        end
        total++; if (exp_q.size() != 0 || bus.Valid) begin bad++; $display("FAIL setwin_drain left=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_priority();
        int n;
        int e;
        do_reset();
        bus.Enable = 1'b1;
        bus.Ready  = 1'b1;
        bus.Y[0]   = 1'b1;
        bus.Y[1]   = 1'b1;
        bus.Y[8]   = 1'b1;
        for (int r = 0; r < 2; r++) begin
`ifdef ENC_ROUND_ROBIN_EN
            exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(8);
`else
            exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0);
            exp_q.push_back(1);
`endif
        end
        n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            if (bus.Valid && bus.Ready) begin
                e = exp_q.pop_front();
                total++; if (bus.W !== 4'(e)) begin bad++; $display("FAIL prio_order got=%0d want=%0d", bus.W, e); end
                total++; if (bus.Pending !== 5'd3) begin bad++; $display("FAIL prio_Pending got=%0d want=3", bus.Pending); end
            end
            cyc();
            n++;
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL prio_timeout left=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_midreset();
        do_reset();
        bus.Enable = 1'b1;
        bus.Y[1]   = 1'b1;
        bus.Y[2]   = 1'b1;
        cyc();
        bus.Y = '0;
        cyc();
        total++; if (bus.Valid !== 1'b1) begin bad++; $display("FAIL mid_pre_Valid got=%b want=1", bus.Valid); end
        #2;
        Resetn = 1'b0;
        #1;
        total++; if (bus.Valid !== 1'b0)   begin bad++; $display("FAIL mid_async_Valid got=%b want=0", bus.Valid); end
        total++; if (bus.Pending !== 5'd0) begin bad++; $display("FAIL mid_async_Pending got=%0d want=0", bus.Pending); end
        cyc();
        Resetn    = 1'b1;
        bus.Ready = 1'b1;
        cyc();
        cyc();
        total++; if (bus.Valid !== 1'b0 || bus.Pending !== 5'd0) begin bad++; $display("FAIL mid_dropped got=%b/%0d want=0/0", bus.Valid, bus.Pending); end
    endtask

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog got=timeout want=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.Y      = '0;
        bus.Enable = 1'b0;
        bus.Ready  = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_set_wins();
        test_priority();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
